lcd_bus_driver: RTL and testbench
=================================

Name: lcd_bus_driver

Overview:
- Hardware HD44780-style character-LCD driver; the device-side counterpart of the CPU's LCD output register.
- LSU issues byte writes (command or data) over a valid/ready handshake.
- Block generates RS/RW/EN/DATA pin timing, enforces the execution delay, and exposes pins packed in the o_io_lcd register format.
- Sits between the LSU output-peripheral decode and the board LCD pins; software no longer bit-bangs EN.

Parameters:
SETUP_CYC, 2, cycles RS/DATA stable before EN rises (min 1)
EN_CYC, 12, cycles EN held high (min 1)
HOLD_CYC, 1, cycles RS/DATA held after EN falls (min 1)
EXEC_CYC, 1850, post-write wait for normal commands/data (37 us @ 50 MHz) (min 1)
LONG_CYC, 76000, post-write wait for clear/home commands (1.52 ms @ 50 MHz)
INIT_WAIT_CYC, 2000000, power-on wait before init sequence (LCD_INIT_EN only)

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_req_vld  in  1  write request valid
o_req_rdy  out  1  ready to accept request
i_req_rs  in  1  0 = command, 1 = data
i_req_data  in  8  byte to write
o_busy  out  1  high whenever the state is not IDLE
o_lcd_on  out  1  LCD power/backlight enable
o_lcd_en  out  1  LCD enable strobe
o_lcd_rs  out  1  LCD register select
o_lcd_rw  out  1  LCD read/write, constant 0
o_lcd_data  out  8  LCD data bus
o_io_lcd  out  32  packed: [31]=on, [10]=en, [9]=rs, [8]=rw, [7:0]=data, other bits 0

Behaviour:
- Reset (async, i_rstn=0): all outputs 0. Includes o_req_rdy=0, o_busy=0, o_io_lcd=0. FSM forced to its first state; counter cleared. Reset mid-transaction aborts it immediately (EN drops to 0 asynchronously).
- After reset release: o_lcd_on=1 from the first clock edge onward.
- States: INIT_WAIT, INIT_CMD (both LCD_INIT_EN only), IDLE, SETUP, PULSE, HOLD, EXEC.
- One down-counter; each timed state lasts exactly its parameter count of cycles. Load N-1 on entry; leave when the counter reaches 0.
- IDLE:
  - o_req_rdy=1, o_busy=0.
  - Accept on the edge where i_req_vld && o_req_rdy. Latch rs/data, go to SETUP.
  - o_req_rdy and o_busy are registered: o_req_rdy=0 and o_busy=1 from the cycle after acceptance.
  - A request held across non-IDLE cycles is not accepted until IDLE.
- SETUP: o_lcd_rs and o_lcd_data = latched values; EN=0.
- PULSE: EN=1; rs/data stable.
- HOLD: EN=0; rs/data stable.
- EXEC:
  - EN=0; rs/data retain their last values until the next accept.
  - Wait LONG_CYC if rs=0 and data[7:2]==0 and data[1:0]!=0 (clear 0x01, home 0x02/0x03); otherwise EXEC_CYC.
  - Then go to IDLE.
- Transaction length: SETUP_CYC+EN_CYC+HOLD_CYC+EXEC-wait cycles from the cycle after acceptance to the first cycle with o_req_rdy=1.
- Back-to-back: the accept cycle in IDLE is the minimum gap (one IDLE cycle between transactions).
- o_io_lcd mirrors the individual pin outputs in the same cycle (same registers, no extra latency).
- Counter width: clog2 of the largest timing parameter; no wrap-around is possible.

Optional Feature:
- LCD_INIT_EN defined:
  - After reset, enter INIT_WAIT for INIT_WAIT_CYC cycles.
  - INIT_CMD then issues 0x38, 0x0C, 0x01, 0x06 (rs=0) in order, each through SETUP/PULSE/HOLD/EXEC with the normal delay rules (0x01 uses LONG_CYC).
  - Then IDLE.
  - o_busy=1 and o_req_rdy=0 throughout init.
- LCD_INIT_EN undefined: the FSM enters IDLE directly; o_req_rdy=1 from the first cycle after reset release.

Test Plan (SETUP_CYC=2, EN_CYC=3, HOLD_CYC=1, EXEC_CYC=5, LONG_CYC=20, INIT_WAIT_CYC=10):
- Reset asserted -> all outputs 0. Release without LCD_INIT_EN -> o_req_rdy=1, o_lcd_on=1 after one edge, o_io_lcd=32'h8000_0000.
- Data write rs=1, data=8'h41 -> EN high exactly 3 cycles, starting 2 cycles after SETUP entry. o_io_lcd=32'h8000_0641 during PULSE. o_req_rdy returns after exactly 11 cycles.
- Command 8'h01 rs=0 -> EXEC lasts 20 cycles; o_req_rdy returns after 26 cycles. Command 8'h38 -> returns after 11 cycles.
- i_req_vld held high for three back-to-back writes 8'h48, 8'h49, 8'h21 -> each accepted only in IDLE, in order. No data change while EN=1.
- Reset pulsed during PULSE -> EN=0 immediately. After release: IDLE, no residual strobe; the next request completes normally.
- With LCD_INIT_EN -> 10 idle cycles, then four EN pulses carrying 0x38, 0x0C, 0x01, 0x06 with rs=0. o_req_rdy stays 0 until after the 0x06 EXEC completes.

Source files
------------

// File: rtl/lcd_bus_driver.sv
// rtl/lcd_bus_driver.sv - HD44780-style character-LCD bus driver with pin timing and execution delay
// Optional power-on init sequence (0x38, 0x0C, 0x01, 0x06) enabled by defining LCD_INIT_EN.
module lcd_bus_driver #(
  parameter int SETUP_CYC     = 2,
  parameter int EN_CYC        = 12,
  parameter int HOLD_CYC      = 1,
  parameter int EXEC_CYC      = 1850,
  parameter int LONG_CYC      = 76000,
  parameter int INIT_WAIT_CYC = 2000000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic        i_req_rs,
  input  logic [7:0]  i_req_data,
  output logic        o_busy,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic [31:0] o_io_lcd
);

  localparam int M1 = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int M2 = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
  localparam int M3 = (M2 > EXEC_CYC) ? M2 : EXEC_CYC;
  localparam int M4 = (M3 > LONG_CYC) ? M3 : LONG_CYC;
`ifdef LCD_INIT_EN
  localparam int M5 = (M4 > INIT_WAIT_CYC) ? M4 : INIT_WAIT_CYC;
`else
  localparam int M5 = M4;
`endif
  localparam int CW = (M5 > 1) ? $clog2(M5) : 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] LD_LONG  = CW'(LONG_CYC - 1);

  typedef enum logic [2:0] {
    S_INIT_WAIT, S_INIT_CMD, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC
  } state_t;

`ifdef LCD_INIT_EN
  localparam state_t        RST_STATE = S_INIT_WAIT;
  // The init wait is the first timed state, so its load value is the reset value.
  localparam logic [CW-1:0] RST_CNT   = CW'(INIT_WAIT_CYC - 1);
`else
  localparam state_t        RST_STATE = S_IDLE;
  localparam logic [CW-1:0] RST_CNT   = '0;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic            en_q, en_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            on_q;
  logic            cnt_zero;
  logic            long_cmd;

`ifdef LCD_INIT_EN
  logic            init_q, init_d;
  logic [1:0]      idx_q, idx_d;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction
`endif

  assign cnt_zero = (cnt_q == '0);
  // Clear (0x01) and return-home (0x02/0x03) need the long execution delay.
  assign long_cmd = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - CW'(1);
    rs_d    = rs_q;
    data_d  = data_q;
`ifdef LCD_INIT_EN
    init_d  = init_q;
    idx_d   = idx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_req_vld && rdy_q) begin
          state_d = S_SETUP;
          cnt_d   = LD_SETUP;
          rs_d    = i_req_rs;
          data_d  = i_req_data;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_PULSE;
          cnt_d   = LD_EN;
        end
      end
      S_PULSE: begin
        if (cnt_zero) begin
          state_d = S_HOLD;
          cnt_d   = LD_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_d = S_EXEC;
          cnt_d   = long_cmd ? LD_LONG : LD_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_zero) begin
`ifdef LCD_INIT_EN
          state_d = init_q ? S_INIT_CMD : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef LCD_INIT_EN
      S_INIT_WAIT: begin
        if (cnt_zero) state_d = S_INIT_CMD;
      end
      S_INIT_CMD: begin
        state_d = S_SETUP;
        cnt_d   = LD_SETUP;
        rs_d    = 1'b0;
        data_d  = init_byte(idx_q);
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) init_d = 1'b0;
      end
`endif
      default: state_d = RST_STATE;
    endcase

    // Handshake and strobe are registered from the next state, so they line up with state_q.
    rdy_d  = (state_d == S_IDLE);
    busy_d = (state_d != S_IDLE);
    en_d   = (state_d == S_PULSE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= RST_STATE;
      cnt_q   <= RST_CNT;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      on_q    <= 1'b0;
`ifdef LCD_INIT_EN
      init_q  <= 1'b1;
      idx_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      on_q    <= 1'b1;
`ifdef LCD_INIT_EN
      init_q  <= init_d;
      idx_q   <= idx_d;
`endif
    end
  end

  assign o_req_rdy  = rdy_q;
  assign o_busy     = busy_q;
  assign o_lcd_on   = on_q;
  assign o_lcd_en   = en_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = data_q;
  assign o_io_lcd   = {on_q, 20'd0, en_q, rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb/tb_lcd_bus_driver.sv - scoreboard bench for lcd_bus_driver with randomized writes
module tb_lcd_bus_driver;

  localparam int SETUP_CYC     = 2;
  localparam int EN_CYC        = 3;
  localparam int HOLD_CYC      = 1;
  localparam int EXEC_CYC      = 5;
  localparam int LONG_CYC      = 20;
  localparam int INIT_WAIT_CYC = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic        req_rs = 1'b0;
  logic [7:0]  req_data = 8'h00;
  logic        busy, lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0]  lcd_data;
  logic [31:0] io_lcd;

  lcd_bus_driver #(
    .SETUP_CYC(SETUP_CYC), .EN_CYC(EN_CYC), .HOLD_CYC(HOLD_CYC),
    .EXEC_CYC(EXEC_CYC), .LONG_CYC(LONG_CYC), .INIT_WAIT_CYC(INIT_WAIT_CYC)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_req_vld(req_vld), .o_req_rdy(req_rdy),
    .i_req_rs(req_rs), .i_req_data(req_data), .o_busy(busy), .o_lcd_on(lcd_on),
    .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
    .o_lcd_data(lcd_data), .o_io_lcd(io_lcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         len;
    bit         timed;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 0;
  int   total = 0;
  int   bad = 0;

  function automatic int ref_len(input logic rs, input logic [7:0] d);
    bit slow;
    slow = (rs == 1'b0) && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    return SETUP_CYC + EN_CYC + HOLD_CYC + (slow ? LONG_CYC : EXEC_CYC);
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic monitor();
    int  cyc = 0, t_start = 0, t_en = 0;
    bit  en_p = 0, busy_p = 0, rdy_p = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        have_cur = 0;
        exp_q.delete();
        en_p = 0; busy_p = 0; rdy_p = 0;
      end else begin
        if (busy && !busy_p) t_start = cyc;
        if (lcd_en && !en_p) begin
          if (exp_q.size() == 0) begin
            check("unexpected_en_pulse", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1;
            t_en = cyc;
            check("pulse_rs", lcd_rs, cur.rs);
            check("pulse_data", lcd_data, cur.d);
            check("pulse_rw", lcd_rw, 0);
            check("pulse_io_lcd", io_lcd, {1'b1, 20'd0, 1'b1, cur.rs, 1'b0, cur.d});
            if (cur.timed) check("setup_cycles", cyc - t_start, SETUP_CYC);
          end
        end
        if (lcd_en && have_cur && (lcd_rs != cur.rs || lcd_data != cur.d))
          check("stable_during_en", {lcd_rs, lcd_data}, {cur.rs, cur.d});
        if (!lcd_en && en_p && have_cur) check("en_width", cyc - t_en, EN_CYC);
        if (req_rdy && !rdy_p && have_cur) begin
          if (cur.timed) check("txn_length", cyc - t_start, cur.len);
          check("busy_at_ready", busy, 0);
          have_cur = 0;
        end
        en_p = lcd_en; busy_p = busy; rdy_p = req_rdy;
      end
    end
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d, input bit hold);
    int n = 0;
    exp_t e;
    @(negedge clk);
    req_vld = 1'b1; req_rs = rs; req_data = d;
    while (!req_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_rdy) begin
      check("accept_timeout", 0, 1);
    end else begin
      e.rs = rs; e.d = d; e.len = ref_len(rs, d); e.timed = 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) req_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || have_cur) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (exp_q.size() != 0 || have_cur), 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       rs;
    int         n;
    exp_t       e;
    fork
      monitor();
    join_none

    #12;
    check("rst_rdy", req_rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_on", lcd_on, 0);
    check("rst_en", lcd_en, 0);
    check("rst_io_lcd", io_lcd, 0);

`ifdef LCD_INIT_EN
    foreach (e.d[i]) begin end
    for (int i = 0; i < 4; i++) begin
      e.rs = 0; e.timed = 0; e.len = 0;
      e.d = (i == 0) ? 8'h38 : (i == 1) ? 8'h0C : (i == 2) ? 8'h01 : 8'h06;
      exp_q.push_back(e);
    end
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    while (!req_rdy && n < 400) begin
      @(negedge clk);
      check("init_busy", busy, 1);
      n++;
    end
    check("init_done_queue", exp_q.size(), 0);
    check("init_rdy", req_rdy, 1);
`else
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_rdy", req_rdy, 1);
    check("rel_on", lcd_on, 1);
    check("rel_busy", busy, 0);
    check("rel_io_lcd", io_lcd, 32'h8000_0000);
`endif

    do_write(1'b1, 8'h41, 0);
    drain();
    do_write(1'b0, 8'h01, 0);
    drain();
    do_write(1'b0, 8'h38, 0);
    drain();

    do_write(1'b1, 8'h48, 1);
    do_write(1'b1, 8'h49, 1);
    do_write(1'b1, 8'h21, 0);
    drain();

    // Abort a transaction with reset while EN is high.
    do_write(1'b1, 8'h55, 0);
    n = 0;
    while (!lcd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_pulse", lcd_en, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_en_drop", lcd_en, 0);
    check("async_io_lcd", io_lcd, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_rdy", req_rdy, 1);
    check("post_rst_en", lcd_en, 0);
    do_write(1'b0, 8'h0C, 0);
    drain();

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rs = 1'b0;
        d  = 8'($urandom_range(0, 4));
      end
      do_write(rs, d, ($urandom_range(0, 1) == 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    req_vld = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
